// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : Responder side of the MEM-stage data-memory interface. Accepts
//             one load or store per instruction, models a fixed access latency,
//             returns registered load data for the MEM/WB register, and stalls
//             the pipeline while an access is outstanding.
//  Ports    : clk        - rising-edge clock
//             rst_n      - asynchronous active-low reset
//             mem_read   - load request (level, held by the stalled pipeline)
//             mem_write  - store request (level, held by the stalled pipeline)
//             addr       - byte address; word index = addr[ADDR_WIDTH+1:2]
//             write_data - store data
//             read_data  - registered load data, valid while resp_valid=1
//             resp_valid - one-cycle pulse when an access completes
//             stall      - pipeline hold while an access is outstanding
//             err        - one-cycle pulse with resp_valid on a faulted access
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int LATENCY    = 3     // legal range 1..15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [31:0]           addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  resp_valid,
   output logic                  stall,
   output logic                  err
);

   localparam int         c_DEPTH      = 1 << ADDR_WIDTH;
   localparam logic [1:0] c_ST_IDLE    = 2'd0;
   localparam logic [1:0] c_ST_BUSY    = 2'd1;
   localparam logic [1:0] c_ST_RESP    = 2'd2;
   localparam logic [3:0] c_COUNT_INIT = 4'(LATENCY - 1);

   // Storage is deliberately not reset; it starts from the zero power-up
   // state and keeps its contents across rst_n.
   logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

   logic [1:0]            r_state;
   logic [3:0]            r_count;
   logic [ADDR_WIDTH-1:0] r_word;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_is_write;
   logic                  r_fault;
   logic [DATA_WIDTH-1:0] r_read_data;
   logic                  r_resp_valid;
   logic                  r_err;

   logic                  w_req;
   logic                  w_accept;
   logic [ADDR_WIDTH-1:0] w_in_word;
   logic                  w_in_fault;
   logic                  w_enter_resp;
   logic [ADDR_WIDTH-1:0] w_c_word;
   logic [DATA_WIDTH-1:0] w_c_wdata;
   logic                  w_c_is_write;
   logic                  w_c_fault;
   logic                  w_unused_addr;

   assign w_req      = mem_read | mem_write;
   assign w_accept   = (r_state == c_ST_IDLE) && w_req;
   assign w_in_word  = addr[ADDR_WIDTH+1:2];
   assign w_in_fault = (addr[1:0] != 2'b00) || (mem_read && mem_write);

   // Upper address bits alias onto the array; they are intentionally unused.
   assign w_unused_addr = ^addr[31:ADDR_WIDTH+2];

   // With a single-cycle latency the commit edge is the acceptance edge, so
   // the commit operands come straight from the inputs instead of the capture
   // registers.
   assign w_enter_resp = (LATENCY == 1) ? w_accept
                                        : ((r_state == c_ST_BUSY) && (r_count == 4'd1));
   assign w_c_word     = (LATENCY == 1) ? w_in_word  : r_word;
   assign w_c_wdata    = (LATENCY == 1) ? write_data : r_wdata;
   assign w_c_is_write = (LATENCY == 1) ? mem_write  : r_is_write;
   assign w_c_fault    = (LATENCY == 1) ? w_in_fault : r_fault;

   assign stall      = w_accept || (r_state == c_ST_BUSY);
   assign read_data  = r_read_data;
   assign resp_valid = r_resp_valid;
   assign err        = r_err;

   // The array write lives in the reset block so that a reset arriving while
   // an access is pending can never let the store reach the array.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= c_ST_IDLE;
         r_count      <= 4'd0;
         r_word       <= '0;
         r_wdata      <= '0;
         r_is_write   <= 1'b0;
         r_fault      <= 1'b0;
         r_read_data  <= '0;
         r_resp_valid <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_resp_valid <= w_enter_resp;
         r_err        <= w_enter_resp && w_c_fault;

         case (r_state)
            c_ST_IDLE: begin
               if (w_req) begin
                  r_word     <= w_in_word;
                  r_wdata    <= write_data;
                  r_is_write <= mem_write;
                  r_fault    <= w_in_fault;
                  r_count    <= c_COUNT_INIT;
                  r_state    <= (LATENCY == 1) ? c_ST_RESP : c_ST_BUSY;
               end
            end
            c_ST_BUSY: begin
               r_count <= r_count - 4'd1;
               if (r_count == 4'd1) begin
                  r_state <= c_ST_RESP;
               end
            end
            c_ST_RESP: begin
               // The same instruction is still on the inputs; ignore it.
               r_state <= c_ST_IDLE;
            end
            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase

         if (w_enter_resp) begin
            if (w_c_fault) begin
               r_read_data <= '0;
            end else if (w_c_is_write) begin
               r_mem[w_c_word] <= w_c_wdata;
            end else begin
               r_read_data <= r_mem[w_c_word];
            end
         end
      end
   end

endmodule
`default_nettype wire
